// File: rtl/crate_bridge_regs.sv
// rtl/crate_bridge_regs.sv - Wishbone register block for the crate bridges
// Per-bridge type selects, edge-counted event stickies/counters and a masked interrupt.
module crate_bridge_regs #(
    parameter int NUM_BRIDGES      = 4,
    parameter int TYPE_BITS        = 2,
    parameter int NUM_ADDRESS_BITS = 8
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_n_i,
    input  logic                             wb_cyc_i,
    input  logic                             wb_stb_i,
    input  logic                             wb_we_i,
    input  logic [NUM_ADDRESS_BITS-1:0]      wb_adr_i,
    input  logic [31:0]                      wb_dat_i,
    input  logic [3:0]                       wb_sel_i,
    output logic [31:0]                      wb_dat_o,
    output logic                             wb_ack_o,
    output logic                             wb_err_o,
    output logic                             wb_rty_o,
    input  logic [NUM_BRIDGES-1:0]           bridge_timeout_i,
    input  logic [NUM_BRIDGES-1:0]           bridge_invalid_i,
    output logic [NUM_BRIDGES*TYPE_BITS-1:0] bridge_type_o,
    output logic                             irq_o
);

    logic                             ack_q;
    logic [31:0]                      dat_q;
    logic [NUM_BRIDGES*TYPE_BITS-1:0] type_q, type_d;
    logic [NUM_BRIDGES-1:0]           to_stk_q, to_stk_d;
    logic [NUM_BRIDGES-1:0]           inv_stk_q, inv_stk_d;
    logic [NUM_BRIDGES*16-1:0]        to_cnt_q, to_cnt_d;
    logic [NUM_BRIDGES*16-1:0]        inv_cnt_q, inv_cnt_d;
    logic [NUM_BRIDGES-1:0]           mask_to_q, mask_to_d;
    logic [NUM_BRIDGES-1:0]           mask_inv_q, mask_inv_d;
    logic [NUM_BRIDGES-1:0]           to_in_q, inv_in_q;
    logic                             irq_q;

    logic [NUM_BRIDGES-1:0] to_rise, inv_rise;
    logic                   acc_global;
    logic [2:0]             acc_idx;
    logic [1:0]             acc_off;
    logic [4:0]             acc_goff;
    logic                   acc_bridge_ok;
    logic                   rd_sample;
    logic                   wr_commit;
    logic [31:0]            rd_data;
    logic                   unused_ok;

    assign acc_global    = wb_adr_i[7];
    assign acc_idx       = wb_adr_i[6:4];
    assign acc_off       = wb_adr_i[3:2];
    assign acc_goff      = wb_adr_i[6:2];
    assign acc_bridge_ok = !acc_global && (int'(acc_idx) < NUM_BRIDGES);

    // Data is captured on the strobe cycle; the write lands at the end of the ack cycle.
    assign rd_sample = wb_cyc_i && wb_stb_i && !ack_q;
    assign wr_commit = wb_cyc_i && wb_stb_i && wb_we_i && ack_q;

    assign to_rise  = bridge_timeout_i & ~to_in_q;
    assign inv_rise = bridge_invalid_i & ~inv_in_q;

    assign wb_ack_o      = ack_q & wb_cyc_i;
    assign wb_dat_o      = dat_q;
    assign wb_err_o      = 1'b0;
    assign wb_rty_o      = 1'b0;
    assign bridge_type_o = type_q;
    assign irq_o         = irq_q;
    assign unused_ok     = ^{wb_adr_i[1:0], wb_dat_i, wb_sel_i};

    // A concurrent event wins over a clear, so the count restarts at one.
    function automatic logic [15:0] cnt_next(input logic [15:0] cur,
                                             input logic        clr,
                                             input logic        ev);
        logic [15:0] r;
        if (clr) begin
            r = ev ? 16'd1 : 16'd0;
        end else if (ev && (cur != 16'hFFFF)) begin
            r = cur + 16'd1;
        end else begin
            r = cur;
        end
        return r;
    endfunction

    always_comb begin
        type_d     = type_q;
        to_stk_d   = to_stk_q;
        inv_stk_d  = inv_stk_q;
        to_cnt_d   = to_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        mask_to_d  = mask_to_q;
        mask_inv_d = mask_inv_q;
        for (int b = 0; b < NUM_BRIDGES; b++) begin
            logic hit;
            hit = wr_commit && acc_bridge_ok && (int'(acc_idx) == b);
            if (hit && (acc_off == 2'd0) && wb_sel_i[0]) begin
                type_d[b*TYPE_BITS +: TYPE_BITS] = wb_dat_i[TYPE_BITS-1:0];
            end
            to_stk_d[b]  = (to_stk_q[b] & ~(hit && (acc_off == 2'd1) && wb_dat_i[0]))
                           | to_rise[b];
            inv_stk_d[b] = (inv_stk_q[b] & ~(hit && (acc_off == 2'd1) && wb_dat_i[1]))
                           | inv_rise[b];
            to_cnt_d[b*16 +: 16]  = cnt_next(to_cnt_q[b*16 +: 16],
                                             hit && (acc_off == 2'd2), to_rise[b]);
            inv_cnt_d[b*16 +: 16] = cnt_next(inv_cnt_q[b*16 +: 16],
                                             hit && (acc_off == 2'd3), inv_rise[b]);
        end
        if (wr_commit && acc_global && (acc_goff == 5'd1)) begin
            mask_to_d  = wb_dat_i[NUM_BRIDGES-1:0];
            mask_inv_d = wb_dat_i[16 +: NUM_BRIDGES];
        end
    end

    always_comb begin
        rd_data = '0;
        if (acc_global) begin
            if (acc_goff == 5'd0) begin
                rd_data[NUM_BRIDGES-1:0]   = to_stk_q;
                rd_data[16 +: NUM_BRIDGES] = inv_stk_q;
            end else if (acc_goff == 5'd1) begin
                rd_data[NUM_BRIDGES-1:0]   = mask_to_q;
                rd_data[16 +: NUM_BRIDGES] = mask_inv_q;
            end
        end else begin
            for (int b = 0; b < NUM_BRIDGES; b++) begin
                if (int'(acc_idx) == b) begin
                    case (acc_off)
                        2'd0: rd_data[TYPE_BITS-1:0] = type_q[b*TYPE_BITS +: TYPE_BITS];
                        2'd1: rd_data[1:0]           = {inv_stk_q[b], to_stk_q[b]};
                        2'd2: rd_data[15:0]          = to_cnt_q[b*16 +: 16];
                        default: rd_data[15:0]       = inv_cnt_q[b*16 +: 16];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            type_q     <= '0;
            to_stk_q   <= '0;
            inv_stk_q  <= '0;
            to_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            mask_to_q  <= '0;
            mask_inv_q <= '0;
            to_in_q    <= '0;
            inv_in_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            ack_q      <= wb_cyc_i & wb_stb_i & ~ack_q;
            if (rd_sample) begin
                dat_q <= rd_data;
            end
            type_q     <= type_d;
            to_stk_q   <= to_stk_d;
            inv_stk_q  <= inv_stk_d;
            to_cnt_q   <= to_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            mask_to_q  <= mask_to_d;
            mask_inv_q <= mask_inv_d;
            to_in_q    <= bridge_timeout_i;
            inv_in_q   <= bridge_invalid_i;
            irq_q      <= |({inv_stk_q, to_stk_q} & {mask_inv_q, mask_to_q});
        end
    end

endmodule

// File: tb/tb_crate_bridge_regs.sv
// tb/tb_crate_bridge_regs.sv - directed self-checking bench for crate_bridge_regs
module tb_crate_bridge_regs;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [7:0]  adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic        ack, err, rty;
    logic [3:0]  to_i, inv_i;
    logic [7:0]  type_o;
    logic        irq;

    int checks = 0;
    int errors = 0;

    crate_bridge_regs #(
        .NUM_BRIDGES(4),
        .TYPE_BITS(2),
        .NUM_ADDRESS_BITS(8)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_n_i(rst_n),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_we_i(we),
        .wb_adr_i(adr),
        .wb_dat_i(dat_i),
        .wb_sel_i(sel),
        .wb_dat_o(dat_o),
        .wb_ack_o(ack),
        .wb_err_o(err),
        .wb_rty_o(rty),
        .bridge_timeout_i(to_i),
        .bridge_invalid_i(inv_i),
        .bridge_type_o(type_o),
        .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer; optionally raises timeout[1] so its edge meets the commit edge.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic edge_to1, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        check("xfer_ack", {31'd0, ack}, 32'd1);
        rd = dat_o;
        if (edge_to1) to_i[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] junk;
        xfer(1'b1, a, d, 4'hF, 1'b0, junk);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'd0, 4'hF, 1'b0, r);
        check(tag, r, exp);
    endtask

    initial begin
        logic [31:0] junk;
        int          acks;
        logic        prev_ack;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_i = '0; sel = '0; to_i = '0; inv_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Put state in place, then reset in the middle of a read.
        wr(8'h00, 32'h2);
        wr(8'h84, 32'h1);
        @(negedge clk); to_i[0] = 1'b1;
        @(negedge clk); to_i[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_irq", {31'd0, irq}, 32'd1);
        check("pre_type", {24'd0, type_o}, 32'h02);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_dat", dat_o, 32'h2);
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_type", {24'd0, type_o}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("err_rty", {30'd0, err, rty}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_check("rst_rd_00", 8'h00, 32'd0);
        rd_check("rst_rd_04", 8'h04, 32'd0);
        rd_check("rst_rd_08", 8'h08, 32'd0);
        rd_check("rst_rd_80", 8'h80, 32'd0);
        rd_check("rst_rd_84", 8'h84, 32'd0);

        // CTRL byte lanes on bridge 2.
        xfer(1'b1, 8'h20, 32'h3, 4'h1, 1'b0, junk);
        check("ctrl_type", {24'd0, type_o}, 32'h30);
        rd_check("ctrl_rd", 8'h20, 32'h3);
        xfer(1'b1, 8'h20, 32'h0, 4'h0, 1'b0, junk);
        check("ctrl_nosel_type", {24'd0, type_o}, 32'h30);
        rd_check("ctrl_nosel_rd", 8'h20, 32'h3);

        // Three pulses then a long high level on timeout[1]: four events.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); to_i[1] = 1'b1;
            @(negedge clk); to_i[1] = 1'b0;
        end
        @(negedge clk); to_i[1] = 1'b1;
        repeat (10) @(negedge clk);
        rd_check("edge_tocnt", 8'h18, 32'd4);
        rd_check("edge_status", 8'h14, 32'h1);
        rd_check("edge_summary", 8'h80, 32'h2);
        to_i[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Clears racing a fresh edge.
        xfer(1'b1, 8'h14, 32'h1, 4'hF, 1'b1, junk);
        to_i[1] = 1'b0;
        xfer(1'b1, 8'h18, 32'h0, 4'hF, 1'b1, junk);
        to_i[1] = 1'b0;
        rd_check("race_status", 8'h14, 32'h1);
        rd_check("race_tocnt", 8'h18, 32'h1);
        wr(8'h14, 32'h1);
        wr(8'h18, 32'h0);
        rd_check("clr_status", 8'h14, 32'h0);
        rd_check("clr_tocnt", 8'h18, 32'h0);

        // Saturation: preload counters near the top, then add five edges.
        @(negedge clk);
        force dut.to_cnt_q = {4{16'hFFFD}};
        @(posedge clk);
        @(negedge clk);
        release dut.to_cnt_q;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); to_i[1] = 1'b1;
            @(negedge clk); to_i[1] = 1'b0;
        end
        rd_check("sat_tocnt", 8'h18, 32'h0000FFFF);

        // Masked interrupt from bridge 2 invalid.
        @(negedge clk); inv_i[2] = 1'b1;
        repeat (4) @(negedge clk);
        check("irq_masked", {31'd0, irq}, 32'd0);
        rd_check("irq_summary", 8'h80, 32'h00040002);
        wr(8'h84, 32'h00040000);
        check("irq_mask_commit", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_set", {31'd0, irq}, 32'd1);
        wr(8'h24, 32'h2);
        check("irq_clr_commit", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_clr", {31'd0, irq}, 32'd0);

        // Held strobe on an unmapped bridge index.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h70; dat_i = 32'hFFFFFFFF; sel = 4'hF;
        acks = 0;
        prev_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) begin
                acks++;
                check("hold_dat", dat_o, 32'd0);
                check("hold_single", {31'd0, prev_ack}, 32'd0);
            end
            prev_ack = ack;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("hold_acks", acks, 32'd3);
        check("hold_type", {24'd0, type_o}, 32'h30);
        rd_check("hold_mask", 8'h84, 32'h00040000);
        rd_check("hold_summary", 8'h80, 32'h00000002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
